cpu_ctrl_sequencer: RTL and testbench



---
 rtl/cpu_ctrl_sequencer.sv | 120 ++++++++++++
 tb/tb_cpu_ctrl_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_sequencer.sv
// cpu_ctrl_sequencer
//   Fetch/decode/execute sequencer for the 6-bit CPU. Fetches instruction
//   words from program memory with a ready handshake into an instruction
//   register, then drives the register decoder and ALU datapath controls.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   instr[5:0]        instruction word: [5:3] opcode, [2:0] register index
//   mem_ready         memory data valid on instr (only looked at in FETCH)
//   zero_flag         accumulator-zero flag (only looked at for JZ in EXEC)
//   mem_rd, mem_addr  memory read request / fetch address (always pc)
//   reg_sel[2:0]      register index to the 3-to-8 decoder
//   reg_we, acc_we    register-file / accumulator write enables
//   alu_op[1:0]       00 pass, 01 add, 10 sub, 11 and
//   halted            sequencer is in HALT
module cpu_ctrl_sequencer #(
  parameter int              PC_W     = 6,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [5:0]      instr,
  input  logic            mem_ready,
  input  logic            zero_flag,
  output logic            mem_rd,
  output logic [PC_W-1:0] mem_addr,
  output logic [2:0]      reg_sel,
  output logic            reg_we,
  output logic            acc_we,
  output logic [1:0]      alu_op,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;
  localparam logic [2:0] OP_JZ    = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [5:0]      r_ir;

  logic [2:0]      w_op;
  logic [2:0]      w_rn;
  logic [PC_W-1:0] w_jz_tgt;

  assign w_op     = r_ir[5:3];
  assign w_rn     = r_ir[2:0];
  // Jump target is the register index scaled to an 8-word page.
  assign w_jz_tgt = PC_W'({w_rn, 3'b000});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_RST;
      r_pc    <= RESET_PC;
      r_ir    <= 6'b000000;
    end else begin
      case (r_state)
        S_RST: r_state <= S_FETCH;
        S_FETCH: begin
          // Wait indefinitely for memory; pc advances only on the handshake.
          if (mem_ready) begin
            r_ir    <= instr;
            r_pc    <= r_pc + PC_W'(1);
            r_state <= S_DECODE;
          end
        end
        S_DECODE: r_state <= (w_op == OP_HALT) ? S_HALT : S_EXEC;
        S_EXEC: begin
          if (w_op == OP_JZ && zero_flag) r_pc <= w_jz_tgt;
          r_state <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_RST;
      endcase
    end
  end

  // Moore outputs: decoded from the registered state and IR only.
  assign mem_addr = r_pc;

  always_comb begin
    mem_rd  = 1'b0;
    reg_sel = 3'b000;
    reg_we  = 1'b0;
    acc_we  = 1'b0;
    alu_op  = 2'b00;
    halted  = 1'b0;
    case (r_state)
      S_FETCH:  mem_rd  = 1'b1;
      S_DECODE: reg_sel = w_rn;
      S_EXEC: begin
        reg_sel = w_rn;
        case (w_op)
          OP_LOAD:  acc_we = 1'b1;
          OP_STORE: reg_we = 1'b1;
          OP_ADD: begin acc_we = 1'b1; alu_op = 2'b01; end
          OP_SUB: begin acc_we = 1'b1; alu_op = 2'b10; end
          OP_AND: begin acc_we = 1'b1; alu_op = 2'b11; end
          OP_NOP, OP_JZ, OP_HALT: ;
          default: ;
        endcase
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// tb_cpu_ctrl_sequencer
//   Instruction-level reference: each instruction is walked through its
//   fetch wait states, decode and execute cycles, with expected controls
//   computed from the opcode and a model program counter.
module tb_cpu_ctrl_sequencer;

  logic       clk;
  logic       rst_n;
  logic [5:0] instr;
  logic       mem_ready;
  logic       zero_flag;
  logic       mem_rd;
  logic [5:0] mem_addr;
  logic [2:0] reg_sel;
  logic       reg_we;
  logic       acc_we;
  logic [1:0] alu_op;
  logic       halted;

  int         n_chk;
  int         n_err;
  logic [5:0] m_pc;

  cpu_ctrl_sequencer #(.PC_W(6), .RESET_PC(6'd0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .mem_ready (mem_ready),
    .zero_flag (zero_flag),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .reg_sel   (reg_sel),
    .reg_we    (reg_we),
    .acc_we    (acc_we),
    .alu_op    (alu_op),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // All controls quiet; only halted and the address may be non-zero.
  task automatic chk_idle(input string tag, input logic exp_halt, input logic [5:0] exp_addr);
    chk({tag, "_rd"},   32'(mem_rd), 0);
    chk({tag, "_sel"},  32'(reg_sel), 0);
    chk({tag, "_we"},   32'({reg_we, acc_we}), 0);
    chk({tag, "_alu"},  32'(alu_op), 0);
    chk({tag, "_halt"}, 32'(halted), 32'(exp_halt));
    chk({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
  endtask

  // Entered one cycle into FETCH. Returns in FETCH of the next instruction,
  // in HALT for opcode 111, or still in EXEC when stop_exec is set.
  task automatic do_instr(input logic [5:0] iw, input int waits, input logic zf,
                          input logic stop_exec);
    logic [2:0] op;
    logic       exp_acc;
    logic       exp_reg;
    logic [1:0] exp_alu;
    op = iw[5:3];
    for (int w = 0; w <= waits; w++) begin
      chk("f_rd",   32'(mem_rd), 1);
      chk("f_addr", 32'(mem_addr), 32'(m_pc));
      chk("f_ctl",  32'({reg_we, acc_we, halted, reg_sel, alu_op}), 0);
      mem_ready = (w == waits);
      instr     = (w == waits) ? iw : 6'($urandom);
      zero_flag = 1'($urandom);
      step;
    end
    m_pc      = m_pc + 6'd1;
    mem_ready = 1'($urandom);
    instr     = 6'($urandom);
    // DECODE
    chk("d_rd",   32'(mem_rd), 0);
    chk("d_sel",  32'(reg_sel), 32'(iw[2:0]));
    chk("d_ctl",  32'({reg_we, acc_we, halted, alu_op}), 0);
    chk("d_addr", 32'(mem_addr), 32'(m_pc));
    if (op == 3'd7) begin
      step;
      chk_idle("h0", 1'b1, m_pc);
      return;
    end
    zero_flag = zf;
    step;
    // EXEC
    exp_acc = (op == 3'd1) || (op >= 3'd3 && op <= 3'd5);
    exp_reg = (op == 3'd2);
    exp_alu = (op >= 3'd3 && op <= 3'd5) ? 2'(op - 3'd2) : 2'd0;
    chk("e_rd",   32'(mem_rd), 0);
    chk("e_sel",  32'(reg_sel), 32'(iw[2:0]));
    chk("e_acc",  32'(acc_we), 32'(exp_acc));
    chk("e_reg",  32'(reg_we), 32'(exp_reg));
    chk("e_alu",  32'(alu_op), 32'(exp_alu));
    chk("e_halt", 32'(halted), 0);
    if (stop_exec) return;
    if (op == 3'd6 && zf) m_pc = {iw[2:0], 3'b000};
    mem_ready = 1'($urandom);
    step;
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    mem_ready = 1'($urandom);
    step;
    chk_idle(tag, 1'b0, 6'd0);
    rst_n = 1'b1;
    m_pc  = 6'd0;
    step;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    m_pc  = 6'd0;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    instr = 6'd0;
    zero_flag = 1'b0;
    step;
    step;
    chk_idle("rst", 1'b0, 6'd0);
    rst_n = 1'b1;
    step;

    // Zero-wait program, then a 4-cycle stall on the fetch at pc=2.
    do_instr(6'b001011, 0, 1'b0, 1'b0);
    do_instr(6'b011101, 0, 1'b0, 1'b0);
    do_instr(6'b010110, 4, 1'b0, 1'b0);
    chk("pc3", 32'(mem_addr), 3);

    // JZ taken to 40, then not taken.
    do_instr(6'b110101, 0, 1'b1, 1'b0);
    chk("jz_t", 32'(mem_addr), 40);
    do_instr(6'b110101, 1, 1'b0, 1'b0);
    chk("jz_n", 32'(mem_addr), 41);

    // Random instruction mix (no HALT).
    for (int k = 0; k < 40; k++)
      do_instr({3'($urandom_range(0, 6)), 3'($urandom)}, $urandom_range(0, 3),
               1'($urandom), 1'b0);

    // Jump to 56 and run NOPs through the wrap at 63.
    do_instr(6'b110111, 0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++)
      do_instr({3'b000, 3'($urandom)}, $urandom_range(0, 2), 1'($urandom), 1'b0);
    chk("wrap", 32'(mem_addr), 0);

    // Reset during EXEC of a STORE.
    do_instr(6'b010100, 0, 1'b0, 1'b1);
    pulse_reset("rst_e");
    chk("rst_e_f", 32'(mem_rd), 1);

    do_instr(6'b100001, 2, 1'b0, 1'b0);
    do_instr(6'b101010, 0, 1'b0, 1'b0);

    // HALT: frozen for 20 cycles whatever memory does.
    do_instr(6'b111000, 0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      mem_ready = 1'($urandom);
      instr     = 6'($urandom);
      step;
      chk_idle("halt", 1'b1, m_pc);
    end
    pulse_reset("rst_h");
    do_instr(6'b001111, 0, 1'b0, 1'b0);
    chk("post", 32'(mem_addr), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
